// File: rtl/t03_text_renderer.sv
// Rasterises a 12-character text row. The text and colour are latched at frame start,
// and each pixel passes through a 2-stage pipeline (cell decode, then font lookup).
module t03_text_renderer #(
    parameter logic [9:0] TEXT_X0    = 10'd128,
    parameter logic [9:0] TEXT_Y0    = 10'd224,
    parameter int         SCALE_LOG2 = 2,
    parameter logic [7:0] BG_COLOR   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] alphabet,
    input  logic [7:0]  text_color,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    output logic        out_valid,
    output logic        text_on,
    output logic [7:0]  pixel_color
);

    localparam logic [5:0]  CODE_BLANK  = 6'd37;
    localparam logic [71:0] ALPHA_BLANK = {12{CODE_BLANK}};
    localparam logic [10:0] ROW_W       = 11'd96 << SCALE_LOG2;
    localparam logic [10:0] ROW_H       = 11'd8 << SCALE_LOG2;
    localparam int          CELL_LSB    = SCALE_LOG2 + 3;
    localparam int          CELL_W      = 11 - CELL_LSB;

    // 5x7 glyphs, row 0 in bits [34:30], MSB of each row is the leftmost column.
    function automatic logic [34:0] font_rom(input logic [5:0] code);
        case (code)
            6'd0:  font_rom = 35'b01110_10001_10011_10101_11001_10001_01110;
            6'd1:  font_rom = 35'b00100_01100_00100_00100_00100_00100_01110;
            6'd2:  font_rom = 35'b01110_10001_00001_00010_00100_01000_11111;
            6'd3:  font_rom = 35'b11111_00010_00100_00010_00001_10001_01110;
            6'd4:  font_rom = 35'b00010_00110_01010_10010_11111_00010_00010;
            6'd5:  font_rom = 35'b11111_10000_11110_00001_00001_10001_01110;
            6'd6:  font_rom = 35'b00110_01000_10000_11110_10001_10001_01110;
            6'd7:  font_rom = 35'b11111_00001_00010_00100_01000_01000_01000;
            6'd8:  font_rom = 35'b01110_10001_10001_01110_10001_10001_01110;
            6'd9:  font_rom = 35'b01110_10001_10001_01111_00001_00010_01100;
            6'd10: font_rom = 35'b01110_10001_10001_11111_10001_10001_10001;
            6'd11: font_rom = 35'b11110_10001_10001_11110_10001_10001_11110;
            6'd12: font_rom = 35'b01110_10001_10000_10000_10000_10001_01110;
            6'd13: font_rom = 35'b11100_10010_10001_10001_10001_10010_11100;
            6'd14: font_rom = 35'b11111_10000_10000_11110_10000_10000_11111;
            6'd15: font_rom = 35'b11111_10000_10000_11110_10000_10000_10000;
            6'd16: font_rom = 35'b01110_10001_10000_10111_10001_10001_01111;
            6'd17: font_rom = 35'b10001_10001_10001_11111_10001_10001_10001;
            6'd18: font_rom = 35'b01110_00100_00100_00100_00100_00100_01110;
            6'd19: font_rom = 35'b00111_00010_00010_00010_00010_10010_01100;
            6'd20: font_rom = 35'b10001_10010_10100_11000_10100_10010_10001;
            6'd21: font_rom = 35'b10000_10000_10000_10000_10000_10000_11111;
            6'd22: font_rom = 35'b10001_11011_10101_10101_10001_10001_10001;
            6'd23: font_rom = 35'b10001_10001_11001_10101_10011_10001_10001;
            6'd24: font_rom = 35'b01110_10001_10001_10001_10001_10001_01110;
            6'd25: font_rom = 35'b11110_10001_10001_11110_10000_10000_10000;
            6'd26: font_rom = 35'b01110_10001_10001_10001_10101_10010_01101;
            6'd27: font_rom = 35'b11110_10001_10001_11110_10100_10010_10001;
            6'd28: font_rom = 35'b01111_10000_10000_01110_00001_00001_11110;
            6'd29: font_rom = 35'b11111_00100_00100_00100_00100_00100_00100;
            6'd30: font_rom = 35'b10001_10001_10001_10001_10001_10001_01110;
            6'd31: font_rom = 35'b10001_10001_10001_10001_10001_01010_00100;
            6'd32: font_rom = 35'b10001_10001_10001_10101_10101_10101_01010;
            6'd33: font_rom = 35'b10001_10001_01010_00100_01010_10001_10001;
            6'd34: font_rom = 35'b10001_10001_10001_01010_00100_00100_00100;
            6'd35: font_rom = 35'b11111_00001_00010_00100_01000_10000_11111;
            6'd36: font_rom = 35'b00100_00100_00100_00100_00100_00000_00100;
            default: font_rom = 35'd0;
        endcase
    endfunction

    logic [71:0]       shadow_alpha_q;
    logic [7:0]        shadow_color_q;
    logic [10:0]       dx_s;
    logic [10:0]       dy_s;
    logic [CELL_W-1:0] cell_s;
    logic [5:0]        code_d, code_q;
    logic [2:0]        col_d, col_q;
    logic [2:0]        row_d, row_q;
    logic              in_row_d, in_row_q;
    logic              valid1_q;
    logic [7:0]        color1_q;
    logic [34:0]       glyph_s;
    logic [4:0]        row_bits_s;
    logic              glyph_bit_s;
    logic              lit_s;
    logic              out_valid_q;
    logic              text_on_q;
    logic [7:0]        pixel_color_q;

    // Stage-1 decode: offset into the row, which character cell, and the font pixel inside it.
    always_comb begin
        dx_s     = {1'b0, pixel_x} - {1'b0, TEXT_X0};
        dy_s     = {1'b0, pixel_y} - {1'b0, TEXT_Y0};
        cell_s   = dx_s[10:CELL_LSB];
        col_d    = dx_s[SCALE_LOG2+2:SCALE_LOG2];
        row_d    = dy_s[SCALE_LOG2+2:SCALE_LOG2];
        // Explicit >= checks keep pixels left of / above the row from wrapping into it.
        in_row_d = pixel_valid & (pixel_x >= TEXT_X0) & (dx_s < ROW_W)
                 & (pixel_y >= TEXT_Y0) & (dy_s < ROW_H);
        code_d   = 6'd0;
        for (int i = 0; i < 12; i++) begin
            code_d = code_d | ({6{cell_s == CELL_W'(i)}} & shadow_alpha_q[71-6*i -: 6]);
        end
    end

    // Stage-2 glyph lookup; column 5-7 and row 7 fall through to the unlit defaults.
    always_comb begin
        glyph_s = font_rom(code_q);
        case (row_q)
            3'd0:    row_bits_s = glyph_s[34:30];
            3'd1:    row_bits_s = glyph_s[29:25];
            3'd2:    row_bits_s = glyph_s[24:20];
            3'd3:    row_bits_s = glyph_s[19:15];
            3'd4:    row_bits_s = glyph_s[14:10];
            3'd5:    row_bits_s = glyph_s[9:5];
            3'd6:    row_bits_s = glyph_s[4:0];
            default: row_bits_s = 5'b00000;
        endcase
        case (col_q)
            3'd0:    glyph_bit_s = row_bits_s[4];
            3'd1:    glyph_bit_s = row_bits_s[3];
            3'd2:    glyph_bit_s = row_bits_s[2];
            3'd3:    glyph_bit_s = row_bits_s[1];
            3'd4:    glyph_bit_s = row_bits_s[0];
            default: glyph_bit_s = 1'b0;
        endcase
        lit_s = in_row_q & (col_q < 3'd5) & (row_q < 3'd7) & glyph_bit_s;
    end

    // Shadow latch and both pipeline stages; stage 1 always sees the pre-update shadow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_alpha_q <= ALPHA_BLANK;
            shadow_color_q <= 8'h00;
            code_q         <= CODE_BLANK;
            col_q          <= 3'd0;
            row_q          <= 3'd0;
            in_row_q       <= 1'b0;
            valid1_q       <= 1'b0;
            color1_q       <= 8'h00;
            out_valid_q    <= 1'b0;
            text_on_q      <= 1'b0;
            pixel_color_q  <= BG_COLOR;
        end else begin
            if (frame_start) begin
                shadow_alpha_q <= alphabet;
                shadow_color_q <= text_color;
            end else begin
                shadow_alpha_q <= shadow_alpha_q;
                shadow_color_q <= shadow_color_q;
            end
            code_q        <= code_d;
            col_q         <= col_d;
            row_q         <= row_d;
            in_row_q      <= in_row_d;
            valid1_q      <= pixel_valid;
            color1_q      <= shadow_color_q;
            out_valid_q   <= valid1_q;
            text_on_q     <= lit_s;
            pixel_color_q <= lit_s ? color1_q : BG_COLOR;
        end
    end

    assign out_valid   = out_valid_q;
    assign text_on     = text_on_q;
    assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_t03_text_renderer.sv
// Bench for t03_text_renderer: a driver pushes expected pixels into a scoreboard,
// a monitor pops them when out_valid rises and checks cycle-exact latency.
module tb_t03_text_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] alphabet;
    logic [7:0]  text_color;
    logic        frame_start;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        out_valid;
    logic        text_on;
    logic [7:0]  pixel_color;

    always #5 clk = ~clk;

    t03_text_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .alphabet    (alphabet),
        .text_color  (text_color),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .out_valid   (out_valid),
        .text_on     (text_on),
        .pixel_color (pixel_color)
    );

    typedef struct {
        int         due;
        logic       on;
        logic [7:0] col;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         in_code[12];
    int         shadow_code[12];
    logic [7:0] shadow_col;

    // Only glyphs quoted in the reference are used: 'A', '1', and blank/reserved codes.
    logic [4:0] glyph_a [7] = '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
    logic [4:0] glyph_1 [7] = '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref_lit(input int x, input int y);
        int dx, dy, ch, fc, fr;
        logic [4:0] r;
        if (x < 128 || y < 224) return 1'b0;
        dx = x - 128;
        dy = y - 224;
        if (dx >= 384 || dy >= 32) return 1'b0;
        ch = dx / 32;
        fc = (dx % 32) / 4;
        fr = dy / 4;
        if (fc >= 5 || fr >= 7) return 1'b0;
        case (shadow_code[ch])
            10:      r = glyph_a[fr];
            1:       r = glyph_1[fr];
            default: r = 5'b00000;
        endcase
        return r[4 - fc];
    endfunction

    task automatic drive(input logic r, input logic fs, input logic pv, input int x, input int y);
        exp_t e;
        @(negedge clk);
        rst         = r;
        frame_start = fs;
        pixel_valid = pv;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        for (int i = 0; i < 12; i++) alphabet[71-6*i -: 6] = 6'(in_code[i]);
        if (!r) begin
            sb.delete();
            for (int i = 0; i < 12; i++) shadow_code[i] = 37;
            shadow_col = 8'h00;
        end else begin
            if (pv) begin
                e.due = cyc + 2;
                e.on  = ref_lit(x, y);
                e.col = e.on ? shadow_col : 8'h00;
                sb.push_back(e);
            end
            if (fs) begin
                shadow_code = in_code;
                shadow_col  = text_color;
            end
        end
    endtask

    task automatic set_all(input int code);
        for (int i = 0; i < 12; i++) in_code[i] = code;
    endtask

    // Monitor: pops the scoreboard on out_valid, checks idle outputs otherwise.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0 || sb[0].due != cyc) begin
                n_err++;
                $display("FAIL latency: out_valid=1 at cycle %0d, required no output (queued=%0d next_due=%0d)",
                         cyc, sb.size(), (sb.size() != 0) ? sb[0].due : -1);
            end else begin
                mon_e = sb.pop_front();
                if (text_on !== mon_e.on || pixel_color !== mon_e.col) begin
                    n_err++;
                    $display("FAIL pixel @%0d: text_on=%b color=%h, required text_on=%b color=%h",
                             cyc, text_on, pixel_color, mon_e.on, mon_e.col);
                end
            end
        end else begin
            n_cmp++;
            if (out_valid !== 1'b0 || text_on !== 1'b0 || pixel_color !== 8'h00) begin
                n_err++;
                $display("FAIL idle @%0d: out_valid=%b text_on=%b color=%h, required 0/0/00",
                         cyc, out_valid, text_on, pixel_color);
            end
            if (sb.size() != 0 && sb[0].due == cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missing @%0d: out_valid=0, required 1 for a queued pixel", cyc);
                mon_e = sb.pop_front();
            end
        end
    end

    initial begin
        int x, y, c;
        logic fs, pv;
        rst = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        pixel_x = 10'd0; pixel_y = 10'd0; text_color = 8'h00;
        set_all(37);
        alphabet = {12{6'd37}};
        for (int i = 0; i < 12; i++) shadow_code[i] = 37;
        shadow_col = 8'h00;

        // Reset with pixels streaming, then a pixel before any frame_start.
        set_all(37); in_code[0] = 10; text_color = 8'hE4;
        repeat (3) drive(1'b0, 1'b0, 1'b1, 136, 224);
        drive(1'b1, 1'b0, 1'b1, 136, 224);
        drive(1'b1, 1'b0, 1'b0, 0, 0);

        // Glyph hit and edges.
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 136, 224);
        drive(1'b1, 1'b0, 1'b1, 128, 224);
        in_code[11] = 1;
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 148, 224);
        drive(1'b1, 1'b0, 1'b1, 127, 224);
        drive(1'b1, 1'b0, 1'b1, 512, 224);
        drive(1'b1, 1'b0, 1'b1, 511, 224);
        drive(1'b1, 1'b0, 1'b1, 488, 224);
        drive(1'b1, 1'b0, 1'b1, 136, 223);
        drive(1'b1, 1'b0, 1'b1, 136, 256);
        drive(1'b1, 1'b0, 1'b1, 136, 236);

        // Anti-tearing: input changes without frame_start, then coincident frame_start.
        set_all(10); text_color = 8'h1F;
        drive(1'b1, 1'b0, 1'b1, 168, 224);
        drive(1'b1, 1'b1, 1'b1, 168, 224);
        drive(1'b1, 1'b0, 1'b1, 168, 224);

        // Bubble pattern 1,0,1,1.
        drive(1'b1, 1'b0, 1'b1, 136, 224);
        drive(1'b1, 1'b0, 1'b0, 136, 224);
        drive(1'b1, 1'b0, 1'b1, 136, 236);
        drive(1'b1, 1'b0, 1'b1, 140, 228);

        // Blank and reserved codes across the whole row.
        for (int i = 0; i < 12; i++) in_code[i] = (i % 2 == 0) ? 37 : 50;
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        for (int yy = 224; yy < 256; yy++)
            for (int xx = 128; xx < 512; xx++)
                drive(1'b1, 1'b0, 1'b1, xx, yy);

        // Mid-stream reset.
        set_all(10); text_color = 8'hC3;
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 136, 224);
        drive(1'b0, 1'b0, 1'b1, 136, 224);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 136, 224);
        drive(1'b1, 1'b1, 1'b1, 136, 224);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 136, 224);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            fs = ($urandom_range(0, 49) == 0);
            if (fs) begin
                for (int i = 0; i < 12; i++) begin
                    c = $urandom_range(0, 3);
                    in_code[i] = (c == 0) ? 1 : (c == 1) ? 10 : (c == 2) ? 37 : 38 + $urandom_range(0, 25);
                end
                text_color = 8'($urandom_range(0, 255));
            end
            pv = ($urandom_range(0, 4) != 0);
            x  = ($urandom_range(0, 9) < 7) ? $urandom_range(100, 540) : $urandom_range(0, 1023);
            y  = ($urandom_range(0, 9) < 7) ? $urandom_range(216, 264) : $urandom_range(0, 1023);
            drive(($urandom_range(0, 499) != 0), fs, pv, x, y);
        end

        repeat (5) drive(1'b1, 1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d pixels never appeared, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/t03_text_renderer.md
Name: t03_text_renderer

Overview:
- Downstream consumer of the alphabet decoder. Takes the 12-character, 6-bit-per-char `alphabet` word and `text_color`, and rasterises them as one scaled text row on the display.
- Per pixel coordinate from the display scanner, outputs a registered pixel colour and a text-hit flag.
- Latches the text at frame start so mid-frame changes to game state or health never tear.
- Contains a 5x7 font ROM and a 2-stage pixel pipeline.

Parameters:
- TEXT_X0, 10'd128: left edge of the text row, in pixels.
- TEXT_Y0, 10'd224: top edge of the text row, in pixels.
- SCALE_LOG2, 2: each font pixel is drawn as a (2^SCALE_LOG2)² block. Base cell is 8x8, so the default cell is 32x32 and the row is 384x32.
- BG_COLOR, 8'h00: colour output on non-text pixels.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset.
- alphabet, input, 72: 12 char codes; char 0 (leftmost) is [71:66], char 11 is [5:0].
- text_color, input, 8: RGB332 foreground colour.
- frame_start, input, 1: one-cycle pulse at start of vertical blank.
- pixel_valid, input, 1: pixel_x and pixel_y are valid this cycle.
- pixel_x, input, 10: column of the current pixel.
- pixel_y, input, 10: row of the current pixel.
- out_valid, output, 1: pixel_valid delayed 2 cycles.
- text_on, output, 1: the output pixel is a lit glyph pixel.
- pixel_color, output, 8: text_color shadow if text_on, else BG_COLOR.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low (`rst`). All state updates on the rising edge of `clk`.
- Reset (rst=0 at the edge):
  - Shadow alphabet becomes 12 copies of code 37 (blank); shadow colour becomes 8'h00.
  - All pipeline registers clear; out_valid=0, text_on=0, pixel_color=BG_COLOR.
  - A reset mid-frame discards in-flight pixels. There is no partial output after reset.
- Shadow update:
  - On a frame_start edge, shadow_alpha←alphabet and shadow_color←text_color.
  - Between pulses the shadows hold.
  - If frame_start and pixel_valid coincide, that pixel uses the pre-update shadow.
- Stage 1 (registered):
  - dx = pixel_x − TEXT_X0 and dy = pixel_y − TEXT_Y0, computed 11 bits wide.
  - in_row = pixel_valid & pixel_x≥TEXT_X0 & dx < 96<<SCALE_LOG2 & pixel_y≥TEXT_Y0 & dy < 8<<SCALE_LOG2.
  - idx = dx>>(SCALE_LOG2+3), range 0..11. col = (dx>>SCALE_LOG2)[2:0]; row = (dy>>SCALE_LOG2)[2:0].
  - Register: code = shadow_alpha[71−6·idx −: 6], col, row, in_row, the delayed valid, and shadow_color.
- Stage 2 (registered):
  - Font ROM lookup: code → 7 rows × 5 bits, row 0 at top, MSB = leftmost column.
  - lit = in_row & col<5 & row<7 & glyph[row][4−col].
  - Columns 5–7 and row 7 are inter-character spacing and are never lit.
  - text_on←lit; pixel_color←lit ? color : BG_COLOR; out_valid←valid.
- Latency: exactly 2 cycles from pixel_valid to out_valid. Full throughput, one pixel per cycle. Bubbles (pixel_valid=0) propagate as out_valid=0 with text_on=0.
- Char codes:
  - 0–9 are digits '0'–'9'; 10–35 are 'A'–'Z'; 36 is '!'.
  - 37 is blank. 38–63 are reserved and render blank.
- Fixed glyph rows for verification:
  - 'A'(10): 01110, 10001, 10001, 11111, 10001, 10001, 10001.
  - '1'(1): 00100, 01100, 00100, 00100, 00100, 00100, 01110.
- Boundaries:
  - pixel_x<TEXT_X0 or pixel_y<TEXT_Y0 must not wrap into the row (comparison is explicit).
  - dx=383 is in the row; dx=384 is outside.
  - pixel_color is BG_COLOR whenever out_valid=0.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with pixel_valid=1 → out_valid=0, text_on=0, pixel_color=8'h00. After release, before any frame_start, pixel (136,224) → text_on=0, since the shadow is blank.
2. Glyph hit: alphabet={6'd10, 11×6'd37}, text_color=8'hE4, pulse frame_start. Pixel (136,224) (col 2, row 0 of 'A') → 2 cycles later out_valid=1, text_on=1, pixel_color=8'hE4. Pixel (128,224) → text_on=0, pixel_color=8'h00.
3. Spacing and edges: pixel (148,224) (col 5) → text_on=0. Pixel (127,224) and (512,224) → out of row, BG. Char 11 = code 1: pixel (128+352+8,224) → text_on=1 ('1' row 0, col 2).
4. Anti-tearing: change alphabet to all 6'd10 mid-frame without frame_start → output still follows the old shadow. Assert frame_start together with pixel_valid → that pixel uses old data; the next frame uses new data.
5. Codes 37 and 50 across the whole 384x32 row → text_on never asserts. A pixel_valid pattern of 1,0,1,1 → out_valid 1,0,1,1 delayed by exactly 2 cycles.
6. Mid-stream reset: stream pixels, drop rst for 1 cycle → out_valid=0 on the next 2 output cycles. Shadow is blank until the next frame_start.
